fft_sequencer: RTL and testbench
================================

// Module: fft_sequencer
// PURPOSE
//  Radix-2 DIT FFT controller that feeds the butterfly datapath and consumes its results. Holds an
//  N-point complex sample RAM: loads samples in bit-reversed order, issues in-place butterflies across
//  log2(N) stages, writes results back, then streams X[0..N-1] out in natural order.
//  Sits between the sample source and the FFT output consumer; drives exactly one butterfly instance.
// PARAMETERS
//  N         8              FFT points; power of two, >= 4
//  WIDTH     8              signed two's-complement width of each re/im component
//  ADDR_W    $clog2(N)      RAM address / butterfly index width
//  TW_SCALE  10             twiddle scale; matches the /10 fixed-point divide in the butterfly
// PORTS
//  i_clk         in   1        clock; all logic on rising edge
//  i_rst_n       in   1        synchronous, active-low reset
//  i_start       in   1        begin a transform; sampled only in IDLE
//  i_in_valid    in   1        input sample valid
//  i_in_re/im    in   WIDTH    input sample, natural order x[0..N-1]
//  o_in_ready    out  1        high in LOAD only
//  o_out_valid   out  1        output sample valid
//  o_out_re/im   out  WIDTH    X[k], k = 0..N-1 in order
//  i_out_ready   in   1        consumer accepts output
//  o_busy        out  1        high in every state except IDLE
//  o_done        out  1        one-cycle pulse when X[N-1] is accepted
//  o_bf_enable   out  1        one-cycle butterfly start pulse
//  o_bf_w_re/im  out  WIDTH    twiddle W_N^k
//  o_bf_xa_re/im out  WIDTH    butterfly top input (RAM[a])
//  o_bf_xb_re/im out  WIDTH    butterfly bottom input (RAM[b])
//  i_bf_ya_re/im in   WIDTH    butterfly top result
//  i_bf_yb_re/im in   WIDTH    butterfly bottom result
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (o_in_ready, o_out_valid, o_busy, o_done, o_bf_enable = 0);
//   counters cleared; RAM contents not cleared. Reset mid-operation aborts; IDLE on the next cycle.
//  IDLE -> LOAD on i_start. i_start while busy is ignored.
//  LOAD: each i_in_valid&&o_in_ready cycle writes RAM[bitrev(n)] and increments n; gaps allowed.
//   After the N-th accept: -> ISSUE; o_in_ready drops the following cycle.
//  Compute loop, stage s = 0..log2(N)-1, span = 2^s, for each group g and j = 0..span-1:
//   a = g*2*span + j, b = a + span, twiddle index k = j*(N/(2*span)).
//   ISSUE (cycle t): o_bf_enable = 1; xa, xb, w driven.
//   WAIT1 (t+1), WAIT2 (t+2): xa, xb, w held stable; o_bf_enable = 0.
//   CAPTURE (t+3): RAM[a] <= ya, RAM[b] <= yb. Then -> ISSUE at t+4, or -> UNLOAD after the last butterfly.
//   Cadence: one butterfly per 4 cycles; compute takes 4*(N/2)*log2(N) cycles (N=8: 12 issues, 48 cycles).
//  Twiddle: W_N^k = round(TW_SCALE*cos(2pi k/N)) - j*round(TW_SCALE*sin(2pi k/N)), k < N/2.
//   For N=8: k0 = (10,0), k1 = (7,-7), k2 = (0,-10), k3 = (-7,-7).
//  UNLOAD: o_out_* are registered. First o_out_valid occurs 1 cycle after UNLOAD entry.
//   Data is held stable while o_out_valid && !i_out_ready. Advance k on each handshake.
//   On the X[N-1] handshake: o_done pulses 1 cycle -> IDLE.
//  Arithmetic: block does no math; results stored as WIDTH-bit values with wrap, no saturation.
//  A stage's writes complete before its next issue; no read-after-write hazard, since CAPTURE precedes ISSUE.
// STRUCTURE
//  fft_pkg: state enum (IDLE, LOAD, ISSUE, WAIT1, WAIT2, CAPTURE, UNLOAD), TW_SCALE, bitrev function.
//  Sub-module fft_twiddle_rom: combinational k -> (w_re, w_im) table generated from N and TW_SCALE.
//  RAM: two WIDTH x N register arrays (re, im); 2 async reads (a, b) and 2 writes.
// TESTING  (bench uses a behavioural butterfly model with the same 3-cycle timing:
//          ya = xa + w*xb/TW_SCALE, yb = xa - w*xb/TW_SCALE)
//  1 Reset, then idle 5 cycles -> all outputs 0; pulse i_start -> o_in_ready=1, o_busy=1 next cycle.
//  2 Impulse x[0]=(10,0), others 0 -> X[0..7] all (10,0); o_done pulses once after X[7].
//  3 DC x[n]=(1,0) for all n -> X[0]=(8,0), X[1..7]=(0,0).
//  4 Count o_bf_enable during compute -> exactly 12 pulses, 4 cycles apart; xa/xb/w stable for 3 cycles
//    after each pulse; observed (a,b,k) sequence matches the loop above.
//  5 Hold i_out_ready=0 for 5 cycles at X[3]; insert 3 i_in_valid gaps during LOAD
//    -> X[3] held unchanged; no sample dropped or duplicated.
//  6 i_start pulsed mid-compute -> ignored. Assert i_rst_n=0 at butterfly 6 -> IDLE next cycle,
//    o_busy=0; a fresh run after reset gives correct results.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT sequencer.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT1,
        WAIT2,
        CAPTURE,
        UNLOAD
    } state_t;

    localparam int DEF_TW_SCALE = 10;

    // Reverse the low 'bits' bits of v; upper bits return as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) begin
            r[i] = v[bits - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle table: k -> W_N^k = round(S*cos(2pi k/N)) - j*round(S*sin(2pi k/N)).
module fft_twiddle_rom
#(
    parameter int N        = 8,
    parameter int WIDTH    = 8,
    parameter int TW_SCALE = 10
) (
    input  logic [$clog2(N)-2:0] i_k,
    output logic [WIDTH-1:0]     o_w_re,
    output logic [WIDTH-1:0]     o_w_im
);

    localparam real PI = 3.14159265358979;

    logic [WIDTH-1:0] w_tab_re [N/2];
    logic [WIDTH-1:0] w_tab_im [N/2];

    // Round half away from zero so the table is symmetric about the axes.
    function automatic int tw_round(input real v);
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end
        return -$rtoi(0.5 - v);
    endfunction

    for (genvar gk = 0; gk < N/2; gk++) begin : g_tw
        localparam real ANG = 2.0 * PI * gk / N;
        assign w_tab_re[gk] = WIDTH'(tw_round(TW_SCALE * $cos(ANG)));
        assign w_tab_im[gk] = WIDTH'(-tw_round(TW_SCALE * $sin(ANG)));
    end

    assign o_w_re = w_tab_re[i_k];
    assign o_w_im = w_tab_im[i_k];

endmodule

// File: rtl/fft_sequencer.sv
// Radix-2 DIT FFT controller: bit-reversed load, in-place butterflies over log2(N) stages, natural-order unload.
//   state   | meaning
//   IDLE    | waiting for i_start
//   LOAD    | accepting N samples into RAM[bitrev(n)]
//   ISSUE   | butterfly start pulse, operands driven
//   WAIT1/2 | butterfly latency, operands held
//   CAPTURE | write ya/yb back to RAM[a]/RAM[b]
//   UNLOAD  | stream X[0..N-1] with valid/ready
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int N        = 8,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = $clog2(N),
    parameter int TW_SCALE = DEF_TW_SCALE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_re,
    input  logic [WIDTH-1:0] i_in_im,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_re,
    output logic [WIDTH-1:0] o_out_im,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_bf_enable,
    output logic [WIDTH-1:0] o_bf_w_re,
    output logic [WIDTH-1:0] o_bf_w_im,
    output logic [WIDTH-1:0] o_bf_xa_re,
    output logic [WIDTH-1:0] o_bf_xa_im,
    output logic [WIDTH-1:0] o_bf_xb_re,
    output logic [WIDTH-1:0] o_bf_xb_im,
    input  logic [WIDTH-1:0] i_bf_ya_re,
    input  logic [WIDTH-1:0] i_bf_ya_im,
    input  logic [WIDTH-1:0] i_bf_yb_re,
    input  logic [WIDTH-1:0] i_bf_yb_im
);

    localparam int STAGE_W = $clog2(ADDR_W + 1);
    localparam int BF_W    = ADDR_W - 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(ADDR_W - 1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_n;
    logic [ADDR_W-1:0]  r_k;
    logic [BF_W-1:0]    r_bf;
    logic [STAGE_W-1:0] r_stage;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_bf_enable;
    logic [WIDTH-1:0]   r_out_re;
    logic [WIDTH-1:0]   r_out_im;
    logic [WIDTH-1:0]   r_ram_re [N];
    logic [WIDTH-1:0]   r_ram_im [N];

    logic [ADDR_W-1:0]  w_span;
    logic [ADDR_W-1:0]  w_j;
    logic [ADDR_W-1:0]  w_a;
    logic [ADDR_W-1:0]  w_b;
    logic [ADDR_W-1:0]  w_load_addr;
    logic [BF_W-1:0]    w_k;
    logic               w_compute;
    logic               w_accept;
    logic [WIDTH-1:0]   w_w_re;
    logic [WIDTH-1:0]   w_w_im;

    // r_bf counts butterflies within a stage as g*span + j.
    always_comb begin
        w_span      = ADDR_W'(1) << r_stage;
        w_j         = ADDR_W'(r_bf) & (w_span - ADDR_W'(1));
        w_a         = ((ADDR_W'(r_bf) >> r_stage) << (r_stage + STAGE_W'(1))) | w_j;
        w_b         = w_a + w_span;
        w_k         = BF_W'(w_j << (LAST_STAGE - r_stage));
        w_load_addr = ADDR_W'(bitrev(32'(r_n), ADDR_W));
        w_compute   = (r_state == ISSUE) || (r_state == WAIT1) ||
                      (r_state == WAIT2) || (r_state == CAPTURE);
        w_accept    = (r_state == LOAD) && i_in_valid && r_in_ready;
    end

    fft_twiddle_rom #(
        .N        (N),
        .WIDTH    (WIDTH),
        .TW_SCALE (TW_SCALE)
    ) u_twiddle_rom (
        .i_k    (w_k),
        .o_w_re (w_w_re),
        .o_w_im (w_w_im)
    );

    // Sample RAM is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_accept) begin
            r_ram_re[w_load_addr] <= i_in_re;
            r_ram_im[w_load_addr] <= i_in_im;
        end
        if (i_rst_n && (r_state == CAPTURE)) begin
            r_ram_re[w_a] <= i_bf_ya_re;
            r_ram_im[w_a] <= i_bf_ya_im;
            r_ram_re[w_b] <= i_bf_yb_re;
            r_ram_im[w_b] <= i_bf_yb_im;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_n         <= '0;
            r_k         <= '0;
            r_bf        <= '0;
            r_stage     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bf_enable <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            r_done      <= 1'b0;
            r_bf_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= LOAD;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_n        <= '0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (r_n == ADDR_W'(N - 1)) begin
                            r_state     <= ISSUE;
                            r_in_ready  <= 1'b0;
                            r_bf_enable <= 1'b1;
                            r_bf        <= '0;
                            r_stage     <= '0;
                        end else begin
                            r_n <= r_n + ADDR_W'(1);
                        end
                    end
                end
                ISSUE:   r_state <= WAIT1;
                WAIT1:   r_state <= WAIT2;
                WAIT2:   r_state <= CAPTURE;
                CAPTURE: begin
                    if (r_bf != '1) begin
                        r_bf        <= r_bf + BF_W'(1);
                        r_state     <= ISSUE;
                        r_bf_enable <= 1'b1;
                    end else if (r_stage != LAST_STAGE) begin
                        r_bf        <= '0;
                        r_stage     <= r_stage + STAGE_W'(1);
                        r_state     <= ISSUE;
                        r_bf_enable <= 1'b1;
                    end else begin
                        r_state <= UNLOAD;
                        r_k     <= '0;
                    end
                end
                UNLOAD: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_re    <= r_ram_re[0];
                        r_out_im    <= r_ram_im[0];
                    end else if (i_out_ready) begin
                        if (r_k == ADDR_W'(N - 1)) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_k      <= r_k + ADDR_W'(1);
                            r_out_re <= r_ram_re[r_k + ADDR_W'(1)];
                            r_out_im <= r_ram_im[r_k + ADDR_W'(1)];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_re    = r_out_re;
    assign o_out_im    = r_out_im;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_bf_enable = r_bf_enable;

    // Operands are only meaningful while a butterfly is in flight; otherwise drive zero.
    assign o_bf_xa_re = w_compute ? r_ram_re[w_a] : '0;
    assign o_bf_xa_im = w_compute ? r_ram_im[w_a] : '0;
    assign o_bf_xb_re = w_compute ? r_ram_re[w_b] : '0;
    assign o_bf_xb_im = w_compute ? r_ram_im[w_b] : '0;
    assign o_bf_w_re  = w_compute ? w_w_re : '0;
    assign o_bf_w_im  = w_compute ? w_w_im : '0;

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: behavioural 3-cycle butterfly plus an array-based FFT reference.
module tb_fft_sequencer;

    localparam int N = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_in_valid = 1'b0;
    logic [7:0] i_in_re = '0;
    logic [7:0] i_in_im = '0;
    logic       i_out_ready = 1'b0;
    logic       o_in_ready, o_out_valid, o_busy, o_done, o_bf_enable;
    logic [7:0] o_out_re, o_out_im;
    logic [7:0] o_bf_w_re, o_bf_w_im, o_bf_xa_re, o_bf_xa_im, o_bf_xb_re, o_bf_xb_im;
    logic [7:0] i_bf_ya_re, i_bf_ya_im, i_bf_yb_re, i_bf_yb_im;

    fft_sequencer dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_in_valid  (i_in_valid),
        .i_in_re     (i_in_re),
        .i_in_im     (i_in_im),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .o_out_re    (o_out_re),
        .o_out_im    (o_out_im),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_bf_enable (o_bf_enable),
        .o_bf_w_re   (o_bf_w_re),
        .o_bf_w_im   (o_bf_w_im),
        .o_bf_xa_re  (o_bf_xa_re),
        .o_bf_xa_im  (o_bf_xa_im),
        .o_bf_xb_re  (o_bf_xb_re),
        .o_bf_xb_im  (o_bf_xb_im),
        .i_bf_ya_re  (i_bf_ya_re),
        .i_bf_ya_im  (i_bf_ya_im),
        .i_bf_yb_re  (i_bf_yb_re),
        .i_bf_yb_im  (i_bf_yb_im)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Twiddles for N=8 with scale 10, written out by hand.
    int tw_re [4] = '{10, 7, 0, -7};
    int tw_im [4] = '{0, -7, -10, -7};

    function automatic int wrap8(input int v);
        int u;
        u = v & 255;
        return (u >= 128) ? u - 256 : u;
    endfunction

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic bfly(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi,
                        output int yar, output int yai, output int ybr, output int ybi);
        int pr, pim;
        pr  = (wr * br - wi * bi) / 10;
        pim = (wr * bi + wi * br) / 10;
        yar = wrap8(ar + pr);
        yai = wrap8(ai + pim);
        ybr = wrap8(ar - pr);
        ybi = wrap8(ai - pim);
    endtask

    // Behavioural butterfly: result appears 3 cycles after the enable cycle.
    logic [31:0] bf_p1 = '0, bf_p2 = '0, bf_p3 = '0;
    always @(posedge i_clk) begin
        int yar, yai, ybr, ybi;
        if (o_bf_enable) begin
            bfly(s8(o_bf_xa_re), s8(o_bf_xa_im), s8(o_bf_xb_re), s8(o_bf_xb_im),
                 s8(o_bf_w_re), s8(o_bf_w_im), yar, yai, ybr, ybi);
            bf_p1 <= {8'(yar), 8'(yai), 8'(ybr), 8'(ybi)};
        end
        bf_p2 <= bf_p1;
        bf_p3 <= bf_p2;
    end
    assign i_bf_ya_re = bf_p3[31:24];
    assign i_bf_ya_im = bf_p3[23:16];
    assign i_bf_yb_re = bf_p3[15:8];
    assign i_bf_yb_im = bf_p3[7:0];

    typedef struct {
        int xar, xai, xbr, xbi, wr, wi;
    } bf_t;

    int  smp_re [N];
    int  smp_im [N];
    int  exp_re [N];
    int  exp_im [N];
    bf_t exp_q [$];

    task automatic ref_fft();
        int mr [N];
        int mi [N];
        int r, span, a, b, k, yar, yai, ybr, ybi;
        exp_q.delete();
        for (int n = 0; n < N; n++) begin
            r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            mr[r] = smp_re[n];
            mi[r] = smp_im[n];
        end
        for (int s = 0; s < 3; s++) begin
            span = 1 << s;
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int j = 0; j < span; j++) begin
                    a = g * 2 * span + j;
                    b = a + span;
                    k = j * (N / (2 * span));
                    exp_q.push_back('{mr[a], mi[a], mr[b], mi[b], tw_re[k], tw_im[k]});
                    bfly(mr[a], mi[a], mr[b], mi[b], tw_re[k], tw_im[k], yar, yai, ybr, ybi);
                    mr[a] = yar; mi[a] = yai; mr[b] = ybr; mi[b] = ybi;
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            exp_re[n] = mr[n];
            exp_im[n] = mi[n];
        end
    endtask

    // Butterfly monitor: operands, cadence and 3-cycle hold after each pulse.
    int     cyc = 0, mon_pulses = 0, last_cyc = 0, hold_cnt = 0, done_cnt = 0;
    bit     mon_en = 1'b0;
    longint held = 0;
    always @(negedge i_clk) begin
        bf_t e;
        cyc++;
        if (o_done) done_cnt++;
        if (!o_busy) hold_cnt = 0;
        if (mon_en && o_bf_enable) begin
            mon_pulses++;
            if (mon_pulses > 1) check("bf_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("bf_extra_pulse", mon_pulses, 12);
            end else begin
                e = exp_q.pop_front();
                check("bf_xa_re", s8(o_bf_xa_re), e.xar);
                check("bf_xa_im", s8(o_bf_xa_im), e.xai);
                check("bf_xb_re", s8(o_bf_xb_re), e.xbr);
                check("bf_xb_im", s8(o_bf_xb_im), e.xbi);
                check("bf_w_re", s8(o_bf_w_re), e.wr);
                check("bf_w_im", s8(o_bf_w_im), e.wi);
            end
            held = longint'({o_bf_xa_re, o_bf_xa_im, o_bf_xb_re, o_bf_xb_im, o_bf_w_re, o_bf_w_im});
            hold_cnt = 3;
        end else if (mon_en && hold_cnt > 0) begin
            check("bf_hold", longint'({o_bf_xa_re, o_bf_xa_im, o_bf_xb_re, o_bf_xb_im,
                                       o_bf_w_re, o_bf_w_im}), held);
            hold_cnt--;
        end
    end

    task automatic run_fft(input int gap_mask, input int stall_k, input int start_bf, input int abort_bf);
        int t;
        bit started;
        logic [7:0] h_re, h_im;
        started = 1'b0;
        ref_fft();
        mon_pulses = 0;
        done_cnt = 0;
        hold_cnt = 0;
        mon_en = 1'b1;
        i_out_ready = 1'b1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("start_in_ready", longint'(o_in_ready), 1);
        check("start_busy", longint'(o_busy), 1);

        for (int n = 0; n < N; n++) begin
            if (gap_mask[n]) begin
                i_in_valid = 1'b0;
                @(posedge i_clk); #1;
            end
            i_in_valid = 1'b1;
            i_in_re = 8'(smp_re[n]);
            i_in_im = 8'(smp_im[n]);
            t = 0;
            while (!o_in_ready && t < 50) begin
                @(posedge i_clk); #1;
                t++;
            end
            if (t >= 50) check("load_timeout", t, 0);
            @(posedge i_clk); #1;
        end
        i_in_valid = 1'b0;
        check("in_ready_drop", longint'(o_in_ready), 0);
        check("first_issue", longint'(o_bf_enable), 1);

        t = 0;
        while (!o_out_valid && t < 300) begin
            if (start_bf > 0 && mon_pulses == start_bf && !started) begin
                i_start = 1'b1;
                started = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            if (abort_bf > 0 && mon_pulses == abort_bf) begin
                i_rst_n = 1'b0;
                @(posedge i_clk); #1;
                i_rst_n = 1'b1;
                check("abort_busy", longint'(o_busy), 0);
                check("abort_bf_enable", longint'(o_bf_enable), 0);
                check("abort_in_ready", longint'(o_in_ready), 0);
                @(posedge i_clk); #1;
                check("abort_stays_idle", longint'(o_busy), 0);
                mon_en = 1'b0;
                exp_q.delete();
                return;
            end
            @(posedge i_clk); #1;
            t++;
            if (started) check("start_ignored", longint'(o_in_ready), 0);
        end
        i_start = 1'b0;
        check("unload_latency", t, 49);
        check("bf_count", mon_pulses, 12);

        for (int k = 0; k < N; k++) begin
            t = 0;
            while (!o_out_valid && t < 20) begin
                @(posedge i_clk); #1;
                t++;
            end
            if (t >= 20) check("out_timeout", t, 0);
            if (k == stall_k) begin
                i_out_ready = 1'b0;
                h_re = o_out_re;
                h_im = o_out_im;
                repeat (5) begin
                    @(posedge i_clk); #1;
                    check("stall_valid", longint'(o_out_valid), 1);
                    check("stall_hold", longint'({o_out_re, o_out_im}), longint'({h_re, h_im}));
                end
                i_out_ready = 1'b1;
            end
            check($sformatf("X%0d_re", k), s8(o_out_re), exp_re[k]);
            check($sformatf("X%0d_im", k), s8(o_out_im), exp_im[k]);
            check("done_early", longint'(o_done), 0);
            @(posedge i_clk); #1;
        end
        check("done_pulse", longint'(o_done), 1);
        check("done_busy", longint'(o_busy), 0);
        check("done_out_valid", longint'(o_out_valid), 0);
        @(posedge i_clk); #1;
        check("done_cleared", longint'(o_done), 0);
        check("done_once", done_cnt, 1);
        check("bf_queue_empty", exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    task automatic fill_random(input int range);
        for (int n = 0; n < N; n++) begin
            smp_re[n] = int'($urandom_range(0, 2 * range)) - range;
            smp_im[n] = int'($urandom_range(0, 2 * range)) - range;
        end
    endtask

    typedef struct {
        bit rst_n;
        bit start;
        bit exp_in_ready;
        bit exp_busy;
    } vec_t;

    initial begin
        vec_t vecs [10];
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0};

        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            i_rst_n = vecs[i].rst_n;
            i_start = vecs[i].start;
            @(posedge i_clk); #1;
            check($sformatf("vec%0d_in_ready", i), longint'(o_in_ready), longint'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d_busy", i), longint'(o_busy), longint'(vecs[i].exp_busy));
            check($sformatf("vec%0d_out_valid", i), longint'(o_out_valid), 0);
            check($sformatf("vec%0d_done", i), longint'(o_done), 0);
            check($sformatf("vec%0d_bf_enable", i), longint'(o_bf_enable), 0);
            check($sformatf("vec%0d_out_data", i), longint'({o_out_re, o_out_im}), 0);
        end
        i_start = 1'b0;
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;

        for (int n = 0; n < N; n++) begin
            smp_re[n] = (n == 0) ? 10 : 0;
            smp_im[n] = 0;
        end
        run_fft(0, -1, 0, 0);

        for (int n = 0; n < N; n++) begin
            smp_re[n] = 1;
            smp_im[n] = 0;
        end
        run_fft(0, -1, 0, 0);

        fill_random(40);
        run_fft(8'b0101_0010, 3, 0, 0);

        fill_random(60);
        run_fft(0, -1, 3, 0);

        fill_random(60);
        run_fft(0, -1, 0, 6);

        fill_random(60);
        run_fft(0, -1, 0, 0);

        for (int r = 0; r < 3; r++) begin
            fill_random(127);
            run_fft(int'($urandom_range(0, 255)), int'($urandom_range(0, N - 1)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
